// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions: FSM states, oversampling and bit-period helper
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  localparam int OVERSAMPLE = 8;
  localparam int OS_BITS    = $clog2(OVERSAMPLE);
  localparam int STOP_BITS  = 1;
  localparam int PRESCALE_W = 16;

  // Terminal count of the bit timer: OVERSAMPLE*max(prescale,1) - 1.
  function automatic logic [PRESCALE_W+OS_BITS-1:0] bit_period_m1(input logic [PRESCALE_W-1:0] prescale);
    logic [PRESCALE_W-1:0] pm1;
    pm1 = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);
    return {pm1, {OS_BITS{1'b1}}};
  endfunction

endpackage

// File: rtl/uart_tx_serializer_bit_timer.sv
// rtl/uart_tx_serializer_bit_timer.sv - loadable down-counter, one-cycle bit_tick per bit period
module uart_bit_timer #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [CNT_W-1:0] load_value,
  output logic             bit_tick
);

  logic [CNT_W-1:0] cnt;

  assign bit_tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (restart || bit_tick) begin
      cnt <= load_value;
    end else begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 UART transmitter with a one-byte holding register
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = PRESCALE_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     data,
  input  logic                      valid,
  output logic                      ready,
  output logic                      txd,
  output logic                      busy,
  input  logic [PRESCALE_WIDTH-1:0] prescale
);

  localparam int CNT_W = PRESCALE_WIDTH + OS_BITS;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  hold_full;
  logic [IDX_W-1:0]      bit_idx;
  logic [CNT_W-1:0]      period_m1;
  logic [CNT_W-1:0]      period_load;
  logic                  bit_tick;
  logic                  load;

  assign ready = !hold_full;
  assign busy  = (state != IDLE) || hold_full;

  // A frame starts from IDLE, or at the last stop-bit edge so frames run back to back.
  assign load        = hold_full && ((state == IDLE) || ((state == STOP) && bit_tick));
  assign period_load = load ? bit_period_m1(prescale) : period_m1;

  uart_bit_timer #(.CNT_W(CNT_W)) u_bit_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .restart    (load),
    .load_value (period_load),
    .bit_tick   (bit_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      txd       <= 1'b1;
      hold      <= '0;
      shreg     <= '0;
      hold_full <= 1'b0;
      bit_idx   <= '0;
      period_m1 <= '0;
    end else begin
      if (valid && ready) begin
        hold      <= data;
        hold_full <= 1'b1;
      end
      if (load) begin
        shreg     <= hold;
        hold_full <= 1'b0;
        txd       <= 1'b0;
        state     <= START;
        period_m1 <= period_load;
        bit_idx   <= '0;
      end else if (bit_tick) begin
        case (state)
          START: begin
            state <= DATA;
            txd   <= shreg[0];
          end
          DATA: begin
            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              shreg   <= shreg >> 1;
              txd     <= shreg[1];
            end
          end
          STOP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;
  import uart_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data;
  logic        valid;
  logic        ready;
  logic        txd;
  logic        busy;
  logic [15:0] prescale;

  int checks = 0;
  int errors = 0;

  bit rec_en = 1'b0;
  bit q[$];
  bit exp_q[$];

  uart_tx_serializer #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .txd      (txd),
    .busy     (busy),
    .prescale (prescale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // txd as seen just after every rising edge
  always @(posedge clk) begin
    #1;
    if (rec_en) q.push_back(txd);
  end

  task automatic start_rec();
    q.delete();
    exp_q.delete();
    exp_q.push_back(1'b1);
    rec_en = 1'b1;
  endtask

  task automatic add_frame(input logic [7:0] b, input int p);
    int pp;
    pp = (p == 0) ? 1 : p;
    for (int i = 0; i < 8 * pp; i++) exp_q.push_back(1'b0);
    for (int j = 0; j < 8; j++)
      for (int i = 0; i < 8 * pp; i++) exp_q.push_back(b[j]);
    for (int i = 0; i < STOP_BITS * 8 * pp; i++) exp_q.push_back(1'b1);
  endtask

  task automatic compare_wave(input string name);
    int bad_idx;
    rec_en = 1'b0;
    exp_q.push_back(1'b1);
    checks++;
    bad_idx = -1;
    if (q.size() == exp_q.size()) begin
      for (int i = 0; i < q.size(); i++)
        if (bad_idx < 0 && q[i] !== exp_q[i]) bad_idx = i;
    end
    if (q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s: waveform length %0d, required %0d", name, q.size(), exp_q.size());
    end else if (bad_idx >= 0) begin
      errors++;
      $display("FAIL %s: txd at cycle %0d is %0b, required %0b", name, bad_idx, q[bad_idx], exp_q[bad_idx]);
    end
  endtask

  task automatic wait_idle(input int limit, output int n);
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      n++;
      @(negedge clk);
    end
    if (n >= limit) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; data = 8'h00; prescale = 16'd1;
    repeat (3) @(negedge clk);
    checks++; if (txd !== 1'b1)   begin errors++; $display("FAIL reset_txd: got %0b, required 1", txd); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b, required 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_p1();
    int n;
    prescale = 16'd1;
    start_rec(); add_frame(8'h55, 1);
    valid = 1'b1; data = 8'h55;
    @(negedge clk);
    valid = 1'b0; data = 8'h00;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL p1_ready_low: got %0b, required 0", ready); end
    checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL p1_busy_rise: got %0b, required 1", busy); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL p1_ready_back: got %0b, required 1", ready); end
    checks++; if (txd !== 1'b0)   begin errors++; $display("FAIL p1_txd_fall: got %0b, required 0", txd); end
    wait_idle(1000, n);
    checks++; if (1 + n != 81) begin errors++; $display("FAIL p1_busy_len: got %0d, required 81", 1 + n); end
    compare_wave("p1_wave_55");
  endtask

  task automatic test_back_to_back();
    int n;
    prescale = 16'd2;
    start_rec(); add_frame(8'h41, 2); add_frame(8'h4E, 2);
    valid = 1'b1; data = 8'h41;
    @(negedge clk);
    data = 8'h4E;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_free: got %0b, required 1", ready); end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_held: ready %0b, required 0", ready); end
    wait_idle(2000, n);
    compare_wave("b2b_wave_41_4e");
  endtask

  task automatic test_third_byte();
    int n;
    int bad;
    prescale = 16'd1;
    start_rec(); add_frame(8'hA0, 1); add_frame(8'h0F, 1); add_frame(8'hC3, 1);
    valid = 1'b1; data = 8'hA0;
    @(negedge clk);
    data = 8'h0F;
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL third_ready_free: got %0b, required 1", ready); end
    @(negedge clk);
    data = 8'hFF;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL third_ready_blocked: ready high %0d times, required 0", bad); end
    data = 8'hC3;
    n = 0;
    while (ready !== 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checks++; if (n != 59) begin errors++; $display("FAIL third_ready_return: after %0d cycles, required 59", n); end
    @(negedge clk);
    valid = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL third_accept: ready %0b, required 0", ready); end
    wait_idle(2000, n);
    compare_wave("third_wave_a0_0f_c3");
  endtask

  task automatic test_prescale_zero();
    int n;
    int lows;
    prescale = 16'd0;
    start_rec(); add_frame(8'h00, 0);
    valid = 1'b1; data = 8'h00;
    @(negedge clk);
    valid = 1'b0;
    wait_idle(1000, n);
    compare_wave("p0_wave_00");
    lows = 0;
    foreach (q[i]) if (q[i] == 1'b0) lows++;
    checks++; if (lows != 72) begin errors++; $display("FAIL p0_low_clocks: got %0d, required 72", lows); end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    prescale = 16'd1;
    valid = 1'b1; data = 8'hA5;
    @(negedge clk);
    data = 8'h99;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (18) @(negedge clk);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL rst_pre_low: txd %0b, required 0", txd); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1)   begin errors++; $display("FAIL rst_async_txd: got %0b, required 1", txd); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %0b, required 1", ready); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_async_busy: got %0b, required 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_rec(); add_frame(8'h3C, 1);
    valid = 1'b1; data = 8'h3C;
    @(negedge clk);
    valid = 1'b0;
    wait_idle(1000, n);
    compare_wave("rst_wave_3c");
  endtask

  task automatic test_prescale_change();
    int n;
    prescale = 16'd1;
    start_rec(); add_frame(8'h96, 1); add_frame(8'h5A, 4);
    valid = 1'b1; data = 8'h96;
    @(negedge clk);
    data = 8'h5A;
    @(negedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (20) @(negedge clk);
    prescale = 16'd4;
    wait_idle(3000, n);
    compare_wave("pchg_wave_96_5a");
  endtask

  initial begin
    test_reset();
    test_single_p1();
    test_back_to_back();
    test_third_byte();
    test_prescale_zero();
    test_reset_mid_frame();
    test_prescale_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
